// File: rtl/blk_781224.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// blk_781224 : BCAM MBIST output handler
//
// Takes the CAM match vector returned for each BIST compare. The expected
// result (hit/miss, entry, mask position) is delayed to line up with the
// array's compare latency. A check is then made for an exact one-hot hit or
// an all-zero miss. Sticky, per-cycle and first-fail diagnostics are reported.
//
// Ports:
//   bist_clk                  in   BIST clock
//   rst_b                     in   async active-low reset
//   BIST_CM_MODE_RF_IN        in   CAM test mode active
//   BIST_CM_EN_RF_IN          in   compare strobe
//   BIST_ROTATE_MASK_RF_IN    in   mask rotate pulse
//   BIST_CD_MASK_ENABLE_RF_IN in   compare-data mask flip enabled
//   BIST_EXP_HIT_RF_IN        in   expected hit when unmasked
//   BIST_EXP_ENTRY_RF_IN      in   expected hitting entry
//   CM_MATCH_RF_OUT           in   match vector from the array
//   BIST_CM_FAIL_CYC          out  one-cycle fail pulse
//   BIST_CM_FAIL              out  sticky fail
//   BIST_CM_FAIL_CNT          out  saturating fail count
//   BIST_CM_FIRST_ENTRY       out  expected entry of the first fail
//   BIST_CM_FIRST_MPOS        out  mask position of the first fail
//   BIST_CM_MPOS              out  current mask position
//   BIST_CM_DONE              out  pipeline drained after mode exit
// ---------------------------------------------------------------------------
module blk_781224 #(
  parameter int RF_DWIDTH  = 72,
  parameter int ENTRIES    = 192,
  parameter int ENTRY_AW   = $clog2(ENTRIES),
  parameter int CM_LATENCY = 2,
  parameter int FAIL_CNT_W = 8
) (
  input  logic                         bist_clk,
  input  logic                         rst_b,
  input  logic                         BIST_CM_MODE_RF_IN,
  input  logic                         BIST_CM_EN_RF_IN,
  input  logic                         BIST_ROTATE_MASK_RF_IN,
  input  logic                         BIST_CD_MASK_ENABLE_RF_IN,
  input  logic                         BIST_EXP_HIT_RF_IN,
  input  logic [ENTRY_AW-1:0]          BIST_EXP_ENTRY_RF_IN,
  input  logic [ENTRIES-1:0]           CM_MATCH_RF_OUT,
  output logic                         BIST_CM_FAIL_CYC,
  output logic                         BIST_CM_FAIL,
  output logic [FAIL_CNT_W-1:0]        BIST_CM_FAIL_CNT,
  output logic [ENTRY_AW-1:0]          BIST_CM_FIRST_ENTRY,
  output logic [$clog2(RF_DWIDTH)-1:0] BIST_CM_FIRST_MPOS,
  output logic [$clog2(RF_DWIDTH)-1:0] BIST_CM_MPOS,
  output logic                         BIST_CM_DONE
);

  localparam int MPW = $clog2(RF_DWIDTH);
  localparam logic [MPW-1:0]      C_MPOS_MAX = MPW'(RF_DWIDTH - 1);
  localparam logic [ENTRY_AW:0]   C_ENTRIES  = (ENTRY_AW + 1)'(ENTRIES);
  localparam logic [2:0]          C_DRAIN_LD = 3'(CM_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t                           r_state;
  state_t                           w_state_nxt;
  logic                             w_enter_active;
  logic                             w_enter_drain;
  logic                             w_drain_done;
  logic [2:0]                       r_drain_cnt;

  logic [MPW-1:0]                   r_mpos;

  // Alignment pipe: one slot per cycle of compare latency
  logic [CM_LATENCY-1:0]                r_pv;
  logic [CM_LATENCY-1:0]                r_ph;
  logic [CM_LATENCY-1:0][ENTRY_AW-1:0]  r_pe;
  logic [CM_LATENCY-1:0][MPW-1:0]       r_pm;

  logic                             w_valid_in;
  logic                             w_hit_in;
  logic [ENTRIES-1:0]               w_exp_vec;
  logic                             w_entry_ok;
  logic                             w_pass;
  logic                             w_fail;

  logic                             r_fail_cyc;
  logic                             r_fail;
  logic [FAIL_CNT_W-1:0]            r_fail_cnt;
  logic [ENTRY_AW-1:0]              r_first_entry;
  logic [MPW-1:0]                   r_first_mpos;
  logic                             r_done;

  // FSM state register
  always_ff @(posedge bist_clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and transition strobes
  always_comb begin
    w_state_nxt    = r_state;
    w_enter_active = 1'b0;
    w_enter_drain  = 1'b0;
    w_drain_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (BIST_CM_MODE_RF_IN) begin
          w_state_nxt    = S_ACTIVE;
          w_enter_active = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ACTIVE: begin
        if (!BIST_CM_MODE_RF_IN) begin
          w_state_nxt   = S_DRAIN;
          w_enter_drain = 1'b1;
        end else begin
          w_state_nxt = S_ACTIVE;
        end
      end
      S_DRAIN: begin
        // Mode re-asserted here still waits for the drain; IDLE then re-enters ACTIVE
        if (r_drain_cnt == 3'd0) begin
          w_state_nxt  = S_IDLE;
          w_drain_done = 1'b1;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Drain down-counter: DRAIN lasts CM_LATENCY cycles
  always_ff @(posedge bist_clk or negedge rst_b) begin
    if (!rst_b) begin
      r_drain_cnt <= 3'd0;
    end else if (w_enter_drain) begin
      r_drain_cnt <= C_DRAIN_LD;
    end else if ((r_state == S_DRAIN) && (r_drain_cnt != 3'd0)) begin
      r_drain_cnt <= r_drain_cnt - 3'd1;
    end else begin
      r_drain_cnt <= r_drain_cnt;
    end
  end

  // Mask position tracks the inhandler's rotating mask in every mode
  always_ff @(posedge bist_clk or negedge rst_b) begin
    if (!rst_b) begin
      r_mpos <= '0;
    end else if (BIST_ROTATE_MASK_RF_IN) begin
      r_mpos <= (r_mpos == C_MPOS_MAX) ? '0 : r_mpos + MPW'(1);
    end else begin
      r_mpos <= r_mpos;
    end
  end

  assign w_valid_in = BIST_CM_EN_RF_IN & (r_state == S_ACTIVE);
  assign w_hit_in   = BIST_EXP_HIT_RF_IN & ~BIST_CD_MASK_ENABLE_RF_IN;

  // Alignment pipe shift; stage 0 samples the pre-rotate mask position
  always_ff @(posedge bist_clk or negedge rst_b) begin
    if (!rst_b) begin
      r_pv <= '0;
      r_ph <= '0;
      r_pe <= '0;
      r_pm <= '0;
    end else begin
      for (int i = CM_LATENCY - 1; i > 0; i--) begin
        r_pv[i] <= r_pv[i-1];
        r_ph[i] <= r_ph[i-1];
        r_pe[i] <= r_pe[i-1];
        r_pm[i] <= r_pm[i-1];
      end
      r_pv[0] <= w_valid_in;
      r_ph[0] <= w_hit_in;
      r_pe[0] <= BIST_EXP_ENTRY_RF_IN;
      r_pm[0] <= r_mpos;
    end
  end

  // An expected hit must be exactly one-hot at a real entry; a miss must be all zero
  assign w_exp_vec  = {{(ENTRIES-1){1'b0}}, 1'b1} << r_pe[CM_LATENCY-1];
  assign w_entry_ok = ({1'b0, r_pe[CM_LATENCY-1]} < C_ENTRIES);
  assign w_pass     = r_ph[CM_LATENCY-1] ? (w_entry_ok && (CM_MATCH_RF_OUT == w_exp_vec))
                                         : (CM_MATCH_RF_OUT == '0);
  assign w_fail     = r_pv[CM_LATENCY-1] & ~w_pass;

  // Fail diagnostics: pulse, sticky flag, saturating count, first-fail capture
  always_ff @(posedge bist_clk or negedge rst_b) begin
    if (!rst_b) begin
      r_fail_cyc    <= 1'b0;
      r_fail        <= 1'b0;
      r_fail_cnt    <= '0;
      r_first_entry <= '0;
      r_first_mpos  <= '0;
    end else begin
      r_fail_cyc <= w_fail;
      if (w_fail) begin
        r_fail <= 1'b1;
        if (r_fail_cnt != {FAIL_CNT_W{1'b1}}) begin
          r_fail_cnt <= r_fail_cnt + FAIL_CNT_W'(1);
        end else begin
          r_fail_cnt <= r_fail_cnt;
        end
        if (!r_fail) begin
          r_first_entry <= r_pe[CM_LATENCY-1];
          r_first_mpos  <= r_pm[CM_LATENCY-1];
        end else begin
          r_first_entry <= r_first_entry;
          r_first_mpos  <= r_first_mpos;
        end
      end else begin
        r_fail        <= r_fail;
        r_fail_cnt    <= r_fail_cnt;
        r_first_entry <= r_first_entry;
        r_first_mpos  <= r_first_mpos;
      end
    end
  end

  // Done flag: set as the drain finishes, held until the next ACTIVE entry
  always_ff @(posedge bist_clk or negedge rst_b) begin
    if (!rst_b) begin
      r_done <= 1'b0;
    end else if (w_drain_done) begin
      r_done <= 1'b1;
    end else if (w_enter_active) begin
      r_done <= 1'b0;
    end else begin
      r_done <= r_done;
    end
  end

  assign BIST_CM_FAIL_CYC    = r_fail_cyc;
  assign BIST_CM_FAIL        = r_fail;
  assign BIST_CM_FAIL_CNT    = r_fail_cnt;
  assign BIST_CM_FIRST_ENTRY = r_first_entry;
  assign BIST_CM_FIRST_MPOS  = r_first_mpos;
  assign BIST_CM_MPOS        = r_mpos;
  assign BIST_CM_DONE        = r_done;

endmodule

// File: doc/blk_781224.md
Name: arf132b192e1r1w0cbbehcaa4acw_bcam_mbist_outhandler

Overview:
Downstream BCAM test stage. Consumes the CAM match vector that the array returns for each BIST compare, which is driven by the inhandler's BIST_CM_DATA_RF_P0. Delay-aligns the expected result with the array's compare latency, checks hit/miss and one-hot correctness, and reports sticky, per-cycle and first-fail diagnostics to MBIST. Tracks the rotating compare-mask position internally, so a masked compare expects a miss.

Parameters:
RF_DWIDTH, 72, compare data width; sets the mask-position wrap point.
ENTRIES, 192, CAM entries; width of the match vector.
ENTRY_AW, $clog2(ENTRIES), width of an entry index.
CM_LATENCY, 2, cycles from compare strobe to a valid match vector; legal range 1..4.
FAIL_CNT_W, 8, width of the fail counter.

Ports:
bist_clk  in  1  BIST clock
rst_b  in  1  async active-low reset
BIST_CM_MODE_RF_IN  in  1  CAM test mode active
BIST_CM_EN_RF_IN  in  1  compare strobe, one per compare
BIST_ROTATE_MASK_RF_IN  in  1  mask rotate pulse, same as the one sent to the inhandler
BIST_CD_MASK_ENABLE_RF_IN  in  1  compare data mask-flip enabled
BIST_EXP_HIT_RF_IN  in  1  expected hit when unmasked
BIST_EXP_ENTRY_RF_IN  in  ENTRY_AW  expected hitting entry
CM_MATCH_RF_OUT  in  ENTRIES  match vector from the array
BIST_CM_FAIL_CYC  out  1  one-cycle fail pulse
BIST_CM_FAIL  out  1  sticky fail
BIST_CM_FAIL_CNT  out  FAIL_CNT_W  saturating fail count
BIST_CM_FIRST_ENTRY  out  ENTRY_AW  expected entry of the first failing compare
BIST_CM_FIRST_MPOS  out  $clog2(RF_DWIDTH)  mask position of the first fail
BIST_CM_MPOS  out  $clog2(RF_DWIDTH)  current mask position
BIST_CM_DONE  out  1  pipeline drained after mode exit

Behaviour:
- Clock and reset: single clock bist_clk. Reset rst_b is asynchronous and active-low. All flops reset asynchronously.
- Reset values: every output is 0. FSM is IDLE. Alignment pipe is cleared.
- Mask position:
  - mpos increments on each BIST_ROTATE_MASK_RF_IN and wraps RF_DWIDTH-1 -> 0.
  - It counts regardless of mode, so it stays in lockstep with the inhandler mask (bit 0 set at reset).
- Expected effective hit:
  - exp_hit_eff = BIST_EXP_HIT_RF_IN & ~BIST_CD_MASK_ENABLE_RF_IN.
  - These values are sampled at the strobe together with EXP_ENTRY and mpos.
- Alignment pipe:
  - CM_LATENCY stages carry {valid, exp_hit_eff, entry, mpos}.
  - valid = BIST_CM_EN_RF_IN & state==ACTIVE.
  - Stage CM_LATENCY-1 valid means a compare is due this cycle; CM_MATCH_RF_OUT is sampled combinationally.
- Check, evaluated when the aligned valid is high:
  - exp_hit_eff=1: pass iff CM_MATCH_RF_OUT is exactly one-hot at entry.
  - exp_hit_eff=0: pass iff CM_MATCH_RF_OUT == 0.
  - Any multi-hit is a fail.
- Fail registration, one cycle after the aligned check:
  - BIST_CM_FAIL_CYC pulses for one cycle.
  - BIST_CM_FAIL sets and stays set until reset.
  - Count increments and saturates at all-ones.
  - FIRST_ENTRY/FIRST_MPOS load only while BIST_CM_FAIL is 0.
- FSM:
  - IDLE -> ACTIVE on CM_MODE=1. BIST_CM_DONE clears on this entry.
  - ACTIVE -> DRAIN on CM_MODE=0. Strobes arriving in DRAIN are ignored.
  - DRAIN runs for CM_LATENCY cycles, counted by a down-counter, checking compares already in flight.
  - DRAIN -> IDLE when the counter reaches 0. BIST_CM_DONE is set on this transition and held until the next ACTIVE entry.
  - CM_MODE=1 during DRAIN: the drain completes first, then the FSM passes through IDLE to ACTIVE on the following cycle.
- Back-to-back strobes every cycle are supported at full throughput.
- Reset mid-operation discards in-flight compares with no fail report. Fail state is cleared.
- A rotate pulse in the same cycle as a strobe: the strobe samples the pre-increment mpos.

Test Plan:
- Reset, CM_MODE=1, strobe with EXP_HIT=1, ENTRY=5, and match=bit5 returned 2 cycles later -> no FAIL_CYC, FAIL=0, CNT=0.
- Same as above but match=bits{5,9} -> FAIL_CYC pulse at strobe+3, FAIL=1, CNT=1, FIRST_ENTRY=5, FIRST_MPOS=0.
- CD_MASK_ENABLE=1, EXP_HIT=1, match=bit5 -> fail, since a miss is expected. With match=0 -> pass.
- 72 rotate pulses -> MPOS walks 0..71 and returns to 0. Induce a fail after 3 rotates -> FIRST_MPOS=3. A second fail at MPOS=10 leaves FIRST_MPOS=3 and gives CNT=2.
- 300 consecutive failing strobes with FAIL_CNT_W=8 -> CNT saturates at 255, FAIL stays 1.
- Strobe, then drop CM_MODE the next cycle -> compare still checked during DRAIN, DONE=1 after 2 cycles. Assert rst_b low mid-pipe -> all outputs 0 immediately, no pulse.
